// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared colour constants, colour type and sizing helper
package game_pkg;

    typedef logic [2:0] color_t;

    localparam color_t BLACK   = 3'b000;
    localparam color_t RED     = 3'b100;
    localparam color_t GREEN   = 3'b010;
    localparam color_t BLUE    = 3'b001;
    localparam color_t YELLOW  = 3'b110;
    localparam color_t MAGENTA = 3'b101;
    localparam color_t CYAN    = 3'b011;
    localparam color_t WHITE   = 3'b111;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// rtl/layer_compositor_if.sv - pixel, configuration and composited-output bundle
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 3
);
    localparam int SEL_W = $clog2(NUM_LAYERS + 1);

    logic [NUM_LAYERS*COLOR_W-1:0] layer_color_i;
    logic                          pix_valid_i;
    logic                          frame_start_i;
    logic                          cfg_wr_i;
    logic [NUM_LAYERS-1:0]         cfg_en_i;
    logic [NUM_LAYERS-1:0]         cfg_blink_i;
    logic [COLOR_W-1:0]            cfg_bg_i;
    logic [COLOR_W-1:0]            color_o;
    logic [SEL_W-1:0]              layer_sel_o;
    logic                          overlap_o;
    logic                          pix_valid_o;

    modport master (
        output layer_color_i, pix_valid_i, frame_start_i,
        output cfg_wr_i, cfg_en_i, cfg_blink_i, cfg_bg_i,
        input  color_o, layer_sel_o, overlap_o, pix_valid_o
    );

    modport slave (
        input  layer_color_i, pix_valid_i, frame_start_i,
        input  cfg_wr_i, cfg_en_i, cfg_blink_i, cfg_bg_i,
        output color_o, layer_sel_o, overlap_o, pix_valid_o
    );

endinterface

// File: rtl/layer_prio_enc.sv
// rtl/layer_prio_enc.sv - lowest-index priority encoder with overlap detect
module layer_prio_enc #(
    parameter int NUM_LAYERS = 4,
    parameter int SEL_W      = $clog2(NUM_LAYERS + 1)
) (
    input  logic [NUM_LAYERS-1:0] visible_i,
    output logic [SEL_W-1:0]      sel_o,
    output logic                  overlap_o
);

    logic seen;

    // sel_o == NUM_LAYERS means no layer is visible (background).
    always_comb begin
        sel_o     = SEL_W'(NUM_LAYERS);
        overlap_o = 1'b0;
        seen      = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (visible_i[k]) begin
                if (!seen) begin
                    sel_o = SEL_W'(k);
                end else begin
                    overlap_o = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - two-stage layer compositor with frame-synchronous config
module layer_compositor
    import game_pkg::*;
#(
    parameter int                    NUM_LAYERS  = 4,
    parameter int                    COLOR_W     = 3,
    parameter logic [COLOR_W-1:0]    TRANSPARENT = '0,
    parameter int                    BLINK_HALF  = 30,
    parameter logic [NUM_LAYERS-1:0] RESET_EN    = '1
) (
    input logic         clk,
    input logic         rst,
    layer_compositor_if.slave bus
);

    localparam int SEL_W = $clog2(NUM_LAYERS + 1);
    localparam int CNT_W = clog2_min1(BLINK_HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    logic [NUM_LAYERS-1:0] shadow_en_q, shadow_en_d;
    logic [NUM_LAYERS-1:0] shadow_blink_q, shadow_blink_d;
    logic [COLOR_W-1:0]    shadow_bg_q, shadow_bg_d;
    logic [NUM_LAYERS-1:0] active_en_q, active_en_d;
    logic [NUM_LAYERS-1:0] active_blink_q, active_blink_d;
    logic [COLOR_W-1:0]    active_bg_q, active_bg_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;

    logic [NUM_LAYERS*COLOR_W-1:0] s1_color_q;
    logic [NUM_LAYERS-1:0]         s1_vis_q, s1_vis_d;
    logic [COLOR_W-1:0]            s1_bg_q;
    logic                          s1_valid_q;

    logic [COLOR_W-1:0] out_color_q, out_color_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic               out_overlap_q, out_overlap_d;
    logic               out_valid_q;

    logic [SEL_W-1:0]   win_sel;
    logic               win_overlap;

    // Stage 1 looks at the post-edge active config so a frame_start update
    // already applies to the pixel presented on that same edge.
    always_comb begin
        shadow_en_d    = shadow_en_q;
        shadow_blink_d = shadow_blink_q;
        shadow_bg_d    = shadow_bg_q;
        active_en_d    = active_en_q;
        active_blink_d = active_blink_q;
        active_bg_d    = active_bg_q;
        frame_cnt_d    = frame_cnt_q;
        blink_phase_d  = blink_phase_q;
        if (bus.cfg_wr_i) begin
            shadow_en_d    = bus.cfg_en_i;
            shadow_blink_d = bus.cfg_blink_i;
            shadow_bg_d    = bus.cfg_bg_i;
        end
        if (bus.frame_start_i) begin
            active_en_d    = shadow_en_q;
            active_blink_d = shadow_blink_q;
            active_bg_d    = shadow_bg_q;
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        for (int k = 0; k < NUM_LAYERS; k++) begin
            s1_vis_d[k] = active_en_d[k]
                        & ~(active_blink_d[k] & blink_phase_d)
                        & (bus.layer_color_i[k*COLOR_W +: COLOR_W] != TRANSPARENT);
        end
    end

    layer_prio_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .SEL_W      (SEL_W)
    ) u_prio (
        .visible_i  (s1_vis_q),
        .sel_o      (win_sel),
        .overlap_o  (win_overlap)
    );

    always_comb begin
        out_color_d   = s1_bg_q;
        out_sel_d     = win_sel;
        out_overlap_d = win_overlap;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (win_sel == SEL_W'(k)) begin
                out_color_d = s1_color_q[k*COLOR_W +: COLOR_W];
            end
        end
        if (!s1_valid_q) begin
            out_color_d   = '0;
            out_sel_d     = SEL_W'(NUM_LAYERS);
            out_overlap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_en_q    <= RESET_EN;
            shadow_blink_q <= '0;
            shadow_bg_q    <= '0;
            active_en_q    <= RESET_EN;
            active_blink_q <= '0;
            active_bg_q    <= '0;
            frame_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            s1_color_q     <= '0;
            s1_vis_q       <= '0;
            s1_bg_q        <= '0;
            s1_valid_q     <= 1'b0;
            out_color_q    <= '0;
            out_sel_q      <= '0;
            out_overlap_q  <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            shadow_en_q    <= shadow_en_d;
            shadow_blink_q <= shadow_blink_d;
            shadow_bg_q    <= shadow_bg_d;
            active_en_q    <= active_en_d;
            active_blink_q <= active_blink_d;
            active_bg_q    <= active_bg_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_phase_q  <= blink_phase_d;
            s1_color_q     <= bus.layer_color_i;
            s1_vis_q       <= s1_vis_d;
            s1_bg_q        <= active_bg_d;
            s1_valid_q     <= bus.pix_valid_i;
            out_color_q    <= out_color_d;
            out_sel_q      <= out_sel_d;
            out_overlap_q  <= out_overlap_d;
            out_valid_q    <= s1_valid_q;
        end
    end

    assign bus.color_o     = out_color_q;
    assign bus.layer_sel_o = out_sel_q;
    assign bus.overlap_o   = out_overlap_q;
    assign bus.pix_valid_o = out_valid_q;

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined successor to the fixed starboy/score/grid colour-priority mux in the game top level.
- Merges NUM_LAYERS per-pixel colour sources into one colour for the VGA driver.
- Adds per-layer enables, per-layer blink, a programmable background and an overlap flag.
- Configuration is double-buffered and takes effect only at a frame boundary, so a frame never tears mid-scan.

Parameters:
- NUM_LAYERS, 4: number of colour sources; layer 0 has the highest priority.
- COLOR_W, 3: bits per colour, {R,G,B} at the default width.
- TRANSPARENT, 0: colour value that means "no pixel" on any layer.
- BLINK_HALF, 30: frames per blink half-period; must be 1 or more.
- RESET_EN, all ones: active layer-enable mask after reset.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  asynchronous, active-high reset
- layer_color_i  in  NUM_LAYERS*COLOR_W  packed colours; layer k occupies bits [k*COLOR_W +: COLOR_W]
- pix_valid_i  in  1  current pixel is inside the active display area
- frame_start_i  in  1  one-cycle pulse at the start of each frame
- cfg_wr_i  in  1  write the shadow configuration registers
- cfg_en_i  in  NUM_LAYERS  layer-enable mask to write
- cfg_blink_i  in  NUM_LAYERS  blink mask to write
- cfg_bg_i  in  COLOR_W  background colour to write
- color_o  out  COLOR_W  composited colour
- layer_sel_o  out  $clog2(NUM_LAYERS+1)  index of the winning layer; the value NUM_LAYERS means background
- overlap_o  out  1  two or more visible layers are non-transparent on this pixel
- pix_valid_o  out  1  pix_valid_i delayed to align with color_o

Behaviour:
- Reset (asynchronous, active-high) clears all pipeline registers:
  - color_o = 0, layer_sel_o = 0, overlap_o = 0, pix_valid_o = 0.
  - Shadow and active enable masks = RESET_EN; shadow and active blink masks = 0; shadow and active background = 0.
  - Frame counter = 0, blink_phase = 0.
- Config write: cfg_wr_i=1 loads the shadow registers from cfg_*_i on that clock edge.
- Frame boundary: frame_start_i=1 copies shadow to active on that edge.
  - If cfg_wr_i and frame_start_i are high together, active receives the shadow value held before the write; the new value applies at the next frame_start_i.
- Blink counter, advanced on each frame_start_i:
  - When frame_cnt reaches BLINK_HALF-1 it wraps to 0 and blink_phase toggles; otherwise frame_cnt increments.
  - The counter width is $clog2(BLINK_HALF), with a minimum of 1.
- Visibility: visible[k] = active_en[k] & ~(active_blink[k] & blink_phase) & (layer k colour != TRANSPARENT).
- Stage 1 (edge 1): register the input colours, the visible mask and pix_valid_i.
- Stage 2 (edge 2), in layer_prio_enc:
  - Winner is the lowest-index visible layer; color_o = that layer's colour.
  - If no layer is visible: color_o = active_bg and layer_sel_o = NUM_LAYERS.
  - overlap_o = popcount(visible) >= 2.
- Invalid pixels: if the registered pix_valid is 0, color_o = 0, layer_sel_o = NUM_LAYERS and overlap_o = 0. This holds blanking black.
- Latency: exactly 2 cycles from inputs to all four outputs; fully pipelined at one pixel per cycle with no stalls.
- Active config and blink_phase are sampled in stage 1, so an update on a frame_start edge affects pixels presented on that same edge or later.
- Mid-operation reset: outputs go to their reset values immediately (asynchronously); the pipeline refills 2 cycles after rst is released.

Decomposition:
- Shared package game_pkg holds:
  - Colour constants BLACK, RED, GREEN, BLUE, YELLOW, MAGENTA, CYAN, WHITE (3-bit).
  - A typedef for color_t.
  - The function clog2_min1 (clog2 with a minimum of 1).
- One sub-module, layer_prio_enc: purely combinational. It takes the visible mask and returns the winning index and the overlap flag.
- The config and blink registers and the pipeline stay in layer_compositor.

Test Plan (defaults: NUM_LAYERS=4, COLOR_W=3):
- Priority: after reset, pix_valid=1, layers = {3:WHITE, 2:GREEN, 1:0, 0:RED} -> 2 cycles later color_o=RED(100), layer_sel_o=0, overlap_o=1.
- Background: all layers 0; write cfg_bg=BLUE, then pulse frame_start -> color_o=BLUE(001), layer_sel_o=4, overlap_o=0. Before the frame_start pulse, color_o=0.
- Double-buffer: cfg_wr with cfg_en=4'b1110 in the same cycle as frame_start, layer0=RED, layer2=GREEN -> color_o stays RED for that frame. After the next frame_start, color_o=GREEN and layer_sel_o=2.
- Blink, with BLINK_HALF=2 and cfg_blink=4'b0001 applied:
  - Two frame_start pulses set blink_phase=1 and give color_o=GREEN (layer 0 hidden).
  - Two more pulses restore color_o=RED.
- Blanking: pix_valid_i=0 with all layers WHITE -> color_o=0, layer_sel_o=4, pix_valid_o=0, each 2 cycles later.
- Reset mid-stream: assert rst asynchronously between clock edges -> all outputs are 0 immediately and active_en=4'b1111. A stream resumed after release produces correct outputs from cycle 2 onward.
